triangle_dispatcher: RTL

- Sits between the triangle assembler and a bank of NUM_UNITS rasterizer units.
- Accepts assembled 168-bit triangles (vertices + color) over a ready/ack handshake.
- Issues each triangle to a free unit by round-robin.
- Tracks frame boundaries and signals frame completion once every issued triangle has been retired.

---
 rtl/triangle_dispatcher.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/triangle_dispatcher.sv
// Round-robin dispatcher from the triangle assembler to NUM_UNITS rasterizer units,
// with frame tracking. Optional stall counter enabled by `define DISPATCH_STALL_CNT_EN.
`timescale 1ns/1ps

module triangle_dispatcher #(
    parameter int NUM_UNITS = 4,
    parameter int TRI_W     = 168,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [TRI_W-1:0]     tri_data,
    input  logic                 tri_ready,
    output logic                 tri_ack,
    input  logic                 frame_end,
    input  logic [NUM_UNITS-1:0] unit_busy,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [TRI_W-1:0]     unit_data,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     frame_tri_count,
`ifdef DISPATCH_STALL_CNT_EN
    output logic                 dispatcher_idle,
    output logic [CNT_W-1:0]     stall_cycles
`else
    output logic                 dispatcher_idle
`endif
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_HOLDOFF = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_sel;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_any_free;
    logic                 w_capture;
    logic [NUM_UNITS-1:0] r_shadow_busy;
    logic [NUM_UNITS-1:0] w_eff_busy;
    logic [CNT_W-1:0]     r_tri_count;
    logic [CNT_W-1:0]     r_frame_tri_count;
    logic                 r_frame_pending;
    logic [TRI_W-1:0]     r_unit_data;

    // A started unit may not show busy until the following cycle; the shadow bit covers that gap.
    assign w_eff_busy = unit_busy | r_shadow_busy;

    always_comb begin : sel_scan
        int               idx;
        logic [IDX_W-1:0] w_idx;
        w_sel      = '0;
        w_any_free = 1'b0;
        idx        = 0;
        w_idx      = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx   = (int'(r_rr_ptr) + k) % NUM_UNITS;
            w_idx = IDX_W'(idx);
            if (!w_any_free && !w_eff_busy[w_idx]) begin
                w_sel      = w_idx;
                w_any_free = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        tri_ack      = 1'b0;
        unit_start   = '0;
        frame_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tri_ready && w_any_free) begin
                    w_capture    = 1'b1;
                    w_next_state = S_LAUNCH;
                end else if (r_frame_pending && !tri_ready && (w_eff_busy == '0)) begin
                    w_next_state = S_DRAIN;
                end
            end
            // NOTE: start/ack are decoded from the state register, so the async reset drops them at once.
            S_LAUNCH: begin
                tri_ack      = 1'b1;
                unit_start   = NUM_UNITS'(1) << r_sel;
                w_next_state = S_HOLDOFF;
            end
            S_HOLDOFF: w_next_state = S_IDLE;
            S_DRAIN: begin
                frame_done   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rr_ptr          <= '0;
            r_sel             <= '0;
            r_shadow_busy     <= '0;
            r_tri_count       <= '0;
            r_frame_tri_count <= '0;
            r_frame_pending   <= 1'b0;
            r_unit_data       <= '1;
        end else begin
            r_shadow_busy <= unit_start;
            if (w_capture) begin
                r_unit_data <= tri_data;
                r_sel       <= w_sel;
            end
            if (r_state == S_LAUNCH) begin
                r_rr_ptr <= (r_sel == IDX_W'(NUM_UNITS - 1)) ? '0 : r_sel + IDX_W'(1);
                if (r_tri_count != '1) r_tri_count <= r_tri_count + CNT_W'(1);
            end
            if (r_state == S_DRAIN) begin
                r_frame_tri_count <= r_tri_count;
                r_tri_count       <= '0;
            end
            // A frame_end arriving while draining opens the next frame rather than being lost.
            if (frame_end)                 r_frame_pending <= 1'b1;
            else if (r_state == S_DRAIN)   r_frame_pending <= 1'b0;
        end
    end

    assign unit_data       = r_unit_data;
    assign frame_tri_count = r_frame_tri_count;
    assign dispatcher_idle = (r_state == S_IDLE) && !r_frame_pending;

`ifdef DISPATCH_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stall_cnt    <= '0;
            r_stall_cycles <= '0;
        end else if (r_state == S_DRAIN) begin
            r_stall_cycles <= r_stall_cnt;
            r_stall_cnt    <= '0;
        end else if ((r_state == S_IDLE) && tri_ready && !w_any_free && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
